// File: rtl/alu_mdu_if.sv
// Operand/result handshake bundle between the execute stage and the ALU/MDU.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, op, a, b,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op, a, b,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative RV32M multiply/divide unit.
// ALU ops and divide special cases complete in one cycle; MUL/DIV
// iterate one bit per cycle and complete WIDTH+2 cycles after acceptance.
module alu_mdu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       reset,
  input logic       flush,
  alu_mdu_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_SLL  = 5'b00110;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic [2:0]         mop_q;      // low opcode bits of the M-op in flight
  logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;        // {hi, lo} product or {remainder, quotient}
  logic               neg_q;      // negate product / quotient in FIX
  logic               rem_neg_q;  // negate remainder in FIX
  logic [SHAMT_W-1:0] cnt;

  logic in_ready, accept;
  assign in_ready = ((state == ST_IDLE) || (state == ST_DONE)) && !flush;
  assign accept   = bus.in_valid && in_ready;

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH:0]     sub;
  logic [SHAMT_W-1:0] shamt;
  logic               ovf, slt, sltu;
  logic [WIDTH-1:0]   alu_res;

  assign sub   = {1'b0, bus.a} - {1'b0, bus.b};
  assign shamt = bus.b[SHAMT_W-1:0];
  assign ovf   = (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (sub[WIDTH-1] ^ bus.a[WIDTH-1]);
  assign slt   = sub[WIDTH-1] ^ ovf;
  assign sltu  = sub[WIDTH];

  // Combinational ALU result; reserved codes fall through to zero.
  always_comb begin
    // NOTE: default assignment first so no path leaves alu_res unassigned (no latch).
    alu_res = '0;
    case (bus.op)
      OP_ADD:  alu_res = bus.a + bus.b;
      OP_SUB:  alu_res = sub[WIDTH-1:0];
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SRA:  alu_res = $signed(bus.a) >>> shamt;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu};
      default: alu_res = '0;
    endcase
  end

  // ---------------- M-op operand preparation ----------------
  logic             is_mop, is_div, a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;

  assign is_mop   = (bus.op[4:3] == 2'b10);
  assign is_div   = bus.op[2];
  // MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned; DIVU/REMU unsigned.
  assign a_signed = is_div ? !bus.op[0] : (bus.op[1:0] != 2'b11);
  assign b_signed = is_div ? !bus.op[0] : !bus.op[1];
  assign a_neg    = a_signed & bus.a[WIDTH-1];
  assign b_neg    = b_signed & bus.b[WIDTH-1];
  assign mag_a    = a_neg ? -bus.a : bus.a;
  assign mag_b    = b_neg ? -bus.b : bus.b;

  // Divide by zero and signed overflow bypass the iteration entirely.
  assign div_zero    = (bus.b == '0);
  assign div_ovf     = !bus.op[0] && (bus.a == MOST_NEG) && (bus.b == '1);
  assign special     = is_div && (div_zero || div_ovf);
  assign special_res = div_zero ? (bus.op[1] ? bus.a : '1)
                                : (bus.op[1] ? '0 : bus.a);

  // ---------------- iteration step ----------------
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  // Shift-add: add multiplicand into the high half when the multiplier LSB is set.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  // Restoring divide: trial-subtract the divisor from the shifted partial remainder.
  assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
  assign div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // ---------------- sign fix-up ----------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // Select the final M-op result half / quotient / remainder.
  always_comb begin
    fix_res = '0;
    if (mop_q[2])            fix_res = mop_q[1] ? rem_fix : quo_fix;
    else if (mop_q[1:0] == 2'b00) fix_res = prod_fix[WIDTH-1:0];
    else                     fix_res = prod_fix[2*WIDTH-1:WIDTH];
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      mop_q     <= '0;
      opnd      <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt       <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (accept) begin
            if (!is_mop) begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
              state    <= ST_DONE;
            end else if (special) begin
              result_q <= special_res;
              zero_q   <= (special_res == '0);
              state    <= ST_DONE;
            end else begin
              mop_q     <= bus.op[2:0];
              opnd      <= is_div ? mag_b : mag_a;
              acc       <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
              neg_q     <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
              cnt       <= SHAMT_W'(WIDTH - 1);
              state     <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc <= mop_q[2] ? div_next : mul_next;
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - SHAMT_W'(1);
        end
        ST_FIX: begin
          result_q <= fix_res;
          zero_q   <= (fix_res == '0);
          state    <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model.
module tb_alu_mdu;

  localparam logic [4:0] ADD = 5'b00000, XOR = 5'b00100, OR = 5'b00011;
  localparam logic [4:0] SLT = 5'b00101, SRA = 5'b01000, SLTU = 5'b01001;
  localparam logic [4:0] MUL = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010, MULHU = 5'b10011;
  localparam logic [4:0] DIV = 5'b10100, DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset, flush32, flush8;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(32)) bus32 ();
  alu_mdu_if #(.WIDTH(8))  bus8 ();

  alu_mdu #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .flush(flush32), .bus(bus32));
  alu_mdu #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .flush(flush8),  .bus(bus8));

  // Reference result from plain integer arithmetic at width w.
  function automatic logic [31:0] model_res(input int w, input logic [4:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    longint mask, ua, ub, sa, sb, r, minv;
    logic [63:0] pu;
    int sh;
    mask = (longint'(1) << w) - 1;
    ua   = {32'b0, a} & mask;
    ub   = {32'b0, b} & mask;
    sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    minv = -(longint'(1) << (w - 1));
    sh   = int'(ub % w);
    case (op)
      5'b00000: r = ua + ub;
      5'b00001: r = ua - ub;
      5'b00010: r = ua & ub;
      5'b00011: r = ua | ub;
      5'b00100: r = ua ^ ub;
      5'b00101: r = (sa < sb) ? 1 : 0;
      5'b00110: r = ua << sh;
      5'b00111: r = ua >> sh;
      5'b01000: r = sa >>> sh;
      5'b01001: r = (ua < ub) ? 1 : 0;
      MUL:      r = sa * sb;
      MULH:     r = (sa * sb) >>> w;
      MULHSU:   r = (sa * ub) >>> w;
      MULHU:    begin pu = 64'(ua) * 64'(ub); r = longint'(pu >> w); end
      DIV:      r = (sb == 0) ? -1 : ((sa == minv && sb == -1) ? sa : sa / sb);
      DIVU:     r = (ub == 0) ? -1 : ua / ub;
      REM:      r = (sb == 0) ? sa : ((sa == minv && sb == -1) ? 0 : sa % sb);
      REMU:     r = (ub == 0) ? ua : ua % ub;
      default:  r = 0;
    endcase
    return 32'(r & mask);
  endfunction

  // Expected latency: iterative M-ops take w+2, everything else 1.
  function automatic int model_lat(input int w, input logic [4:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
    longint mask, ua, ub;
    bit ovf;
    mask = (longint'(1) << w) - 1;
    ua   = {32'b0, a} & mask;
    ub   = {32'b0, b} & mask;
    ovf  = !op[0] && (ua == (longint'(1) << (w - 1))) && (ub == mask);
    if (op[4:3] != 2'b10) return 1;
    if (op[2] && (ub == 0 || ovf)) return 1;
    return w + 2;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0080;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] pick_op();
    if ($urandom_range(0, 1) == 1) return {2'b10, 3'($urandom_range(0, 7))};
    return 5'($urandom_range(0, 31));
  endfunction

  // Issue one op on the 32-bit unit; report result, zero, latency and busy cycles.
  task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int lat, output int busy);
    int guard = 0;
    @(negedge clk);
    bus32.op = op; bus32.a = a; bus32.b = b; bus32.in_valid = 1'b1;
    while (!bus32.in_ready && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    lat = 1; busy = 0;
    while (!bus32.out_valid && lat < 100) begin
      if (!bus32.in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    if (!bus32.out_valid) lat = -1;
    res = bus32.result; z = bus32.zero;
  endtask

  task automatic run8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic [31:0] res, output logic z, output int lat);
    int guard = 0;
    @(negedge clk);
    bus8.op = op; bus8.a = a; bus8.b = b; bus8.in_valid = 1'b1;
    while (!bus8.in_ready && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!bus8.out_valid) lat = -1;
    res = {24'b0, bus8.result}; z = bus8.zero;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus32.result !== 32'h0 || bus32.zero !== 1'b1 || bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset32: result=%h zero=%b out_valid=%b in_ready=%b, want 0 1 0 1",
               bus32.result, bus32.zero, bus32.out_valid, bus32.in_ready);
    end
    checks++;
    if (bus8.result !== 8'h0 || bus8.zero !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset8: result=%h zero=%b out_valid=%b in_ready=%b, want 0 1 0 1",
               bus8.result, bus8.zero, bus8.out_valid, bus8.in_ready);
    end
  endtask

  task automatic test_alu();
    vec_t v[4];
    logic [31:0] res; logic z; int lat, busy;
    v[0] = '{ADD,  32'h7FFF_FFFF, 32'h1,  32'h8000_0000, 1};
    v[1] = '{SLT,  32'h8000_0000, 32'h1,  32'h1,         1};
    v[2] = '{SLTU, 32'h8000_0000, 32'h1,  32'h0,         1};
    v[3] = '{SRA,  32'hF000_0000, 32'h24, 32'hFF00_0000, 1};
    foreach (v[i]) begin
      run32(v[i].op, v[i].a, v[i].b, res, z, lat, busy);
      checks++;
      if (res !== v[i].exp || z !== (v[i].exp == 0) || lat !== v[i].lat) begin
        errors++;
        $display("FAIL alu[%0d] op=%b: result=%h zero=%b lat=%0d, want %h %b %0d",
                 i, v[i].op, res, z, lat, v[i].exp, v[i].exp == 0, v[i].lat);
      end
    end
  endtask

  task automatic test_mul();
    vec_t v[3];
    logic [31:0] res; logic z; int lat, busy;
    v[0] = '{MULH,  32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 34};
    v[1] = '{MULHU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 34};
    v[2] = '{MUL,   32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 34};
    foreach (v[i]) begin
      run32(v[i].op, v[i].a, v[i].b, res, z, lat, busy);
      checks++;
      if (res !== v[i].exp || z !== (v[i].exp == 0) || lat !== v[i].lat || busy !== 33) begin
        errors++;
        $display("FAIL mul[%0d] op=%b: result=%h zero=%b lat=%0d busy=%0d, want %h %b %0d 33",
                 i, v[i].op, res, z, lat, busy, v[i].exp, v[i].exp == 0, v[i].lat);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[4];
    logic [31:0] res; logic z; int lat, busy;
    v[0] = '{DIV,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 34};
    v[1] = '{REM,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 34};
    v[2] = '{DIVU, 32'h7,         32'h0,         32'hFFFF_FFFF, 1};
    v[3] = '{REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
    foreach (v[i]) begin
      run32(v[i].op, v[i].a, v[i].b, res, z, lat, busy);
      checks++;
      if (res !== v[i].exp || z !== (v[i].exp == 0) || lat !== v[i].lat || busy !== v[i].lat - 1) begin
        errors++;
        $display("FAIL div[%0d] op=%b: result=%h zero=%b lat=%0d busy=%0d, want %h %b %0d %0d",
                 i, v[i].op, res, z, lat, busy, v[i].exp, v[i].exp == 0, v[i].lat, v[i].lat - 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops[3]  = '{ADD, XOR, OR};
    logic [31:0] opa[3]  = '{32'd1, 32'd5, 32'd0};
    logic [31:0] opb[3]  = '{32'd1, 32'd5, 32'd0};
    logic [31:0] exp[3]  = '{32'd2, 32'd0, 32'd0};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus32.op = ops[i]; bus32.a = opa[i]; bus32.b = opb[i]; bus32.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus32.out_valid !== 1'b1 || bus32.result !== exp[i] || bus32.zero !== (exp[i] == 0)) begin
        errors++;
        $display("FAIL b2b[%0d]: out_valid=%b result=%h zero=%b, want 1 %h %b",
                 i, bus32.out_valid, bus32.result, bus32.zero, exp[i], exp[i] == 0);
      end
    end
    bus32.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse_end: out_valid=%b, want 0", bus32.out_valid);
    end
  endtask

  // Accept a DIVU, then abort it with flush (use_reset=0) or reset (use_reset=1) at E+10.
  task automatic test_abort(input bit use_reset);
    logic [31:0] res, want_res; logic z, want_z; int lat, busy, seen;
    run32(ADD, 32'd3, 32'd4, res, z, lat, busy);
    checks++;
    if (res !== 32'd7) begin
      errors++;
      $display("FAIL abort_setup: result=%h, want 00000007", res);
    end
    @(negedge clk);
    bus32.op = DIVU; bus32.a = 32'd100; bus32.b = 32'd7; bus32.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    if (use_reset) reset = 1'b1; else flush32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; flush32 = 1'b0;
    #1;
    want_res = use_reset ? 32'h0 : 32'd7;
    want_z   = use_reset;
    checks++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0 || bus32.result !== want_res || bus32.zero !== want_z) begin
      errors++;
      $display("FAIL abort(reset=%0d): in_ready=%b out_valid=%b result=%h zero=%b, want 1 0 %h %b",
               use_reset, bus32.in_ready, bus32.out_valid, bus32.result, bus32.zero, want_res, want_z);
    end
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus32.out_valid) seen++; end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_quiet(reset=%0d): out_valid pulses=%0d, want 0", use_reset, seen);
    end
    if (!use_reset) begin
      @(negedge clk);
      flush32 = 1'b1; bus32.op = ADD; bus32.a = 32'd1; bus32.b = 32'd1; bus32.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush32 = 1'b0; bus32.in_valid = 1'b0;
      checks++;
      if (bus32.out_valid !== 1'b0 || bus32.result !== 32'd7) begin
        errors++;
        $display("FAIL flush_with_valid: out_valid=%b result=%h, want 0 00000007",
                 bus32.out_valid, bus32.result);
      end
    end
  endtask

  task automatic test_random32();
    logic [31:0] a, b, res, exp; logic [4:0] op; logic z; int lat, busy, elat;
    for (int i = 0; i < 60; i++) begin
      op = pick_op(); a = pick_operand(); b = pick_operand();
      run32(op, a, b, res, z, lat, busy);
      exp  = model_res(32, op, a, b);
      elat = model_lat(32, op, a, b);
      checks++;
      if (res !== exp || z !== (exp == 0) || lat !== elat) begin
        errors++;
        $display("FAIL rand32[%0d] op=%b a=%h b=%h: result=%h zero=%b lat=%0d, want %h %b %0d",
                 i, op, a, b, res, z, lat, exp, exp == 0, elat);
      end
    end
  endtask

  task automatic test_width8();
    vec_t v[2];
    logic [31:0] res, exp; logic [7:0] a, b; logic [4:0] op; logic z; int lat, elat;
    v[0] = '{MULHSU,   32'h80, 32'hFF, 32'h80, 10};
    v[1] = '{5'b01111, 32'h05, 32'h03, 32'h00, 1};
    foreach (v[i]) begin
      run8(v[i].op, v[i].a[7:0], v[i].b[7:0], res, z, lat);
      checks++;
      if (res !== v[i].exp || z !== (v[i].exp == 0) || lat !== v[i].lat) begin
        errors++;
        $display("FAIL w8[%0d] op=%b: result=%h zero=%b lat=%0d, want %h %b %0d",
                 i, v[i].op, res, z, lat, v[i].exp, v[i].exp == 0, v[i].lat);
      end
    end
    for (int i = 0; i < 30; i++) begin
      op = pick_op(); a = 8'(pick_operand()); b = 8'(pick_operand());
      run8(op, a, b, res, z, lat);
      exp  = model_res(8, op, {24'b0, a}, {24'b0, b});
      elat = model_lat(8, op, {24'b0, a}, {24'b0, b});
      checks++;
      if (res !== exp || z !== (exp == 0) || lat !== elat) begin
        errors++;
        $display("FAIL rand8[%0d] op=%b a=%h b=%h: result=%h zero=%b lat=%0d, want %h %b %0d",
                 i, op, a, b, res, z, lat, exp, exp == 0, elat);
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush32 = 1'b0; flush8 = 1'b0;
    bus32.in_valid = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0;
    bus8.in_valid  = 1'b0; bus8.op  = '0; bus8.a  = '0; bus8.b  = '0;
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_back_to_back();
    test_abort(1'b0);
    test_random32();
    test_width8();
    test_abort(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, handshaked successor to the core's single-cycle 3-bit-control ALU.
- Width is generic; opcode widens to 5 bits.
- Adds SRA, SLTU and the full RV32M multiply/divide set through a multi-cycle iterative datapath.
- Sits in the execute stage. The hazard unit stalls the pipeline on in_ready=0 and flushes in-flight M-ops through flush.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of 2)
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from b

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous abort of any operation in progress
in_valid  in  1  operands/op presented
in_ready  out  1  unit can accept this cycle
op  in  5  operation code
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  one-cycle pulse: result/zero valid
result  out  WIDTH  registered result
zero  out  1  registered (result == 0)

Behaviour:
- Opcodes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLT (signed), 00110 SLL, 00111 SRL, 01000 SRA, 01001 SLTU.
  - 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - All other codes: result 0, latency as ALU ops.
- Shifts use b[SHAMT_W-1:0] only.
- SLT is computed as sum MSB XOR signed overflow of a-b. SLTU is the borrow of a-b.
- States: IDLE, CALC, FIX, DONE.
- in_ready = (state==IDLE || state==DONE) && !flush.
- A transaction is accepted at edge E when in_valid && in_ready && !reset.
- ALU op (and reserved codes):
  - Result is computed combinationally and registered at E; next state is DONE.
  - out_valid is high the cycle after E (latency 1).
- MUL family:
  - Operands are latched as magnitudes per signedness (MULHSU: a signed, b unsigned). Result sign is latched.
  - CALC runs WIDTH shift-add iterations, one per cycle, into a 2*WIDTH product using a down-counter from WIDTH-1.
  - FIX applies conditional two's-complement negation and selects the low half (MUL) or high half (MULH*).
  - DONE follows. out_valid arrives WIDTH+2 cycles after E.
- DIV family:
  - Restoring radix-2 over magnitudes, WIDTH iterations in CALC.
  - FIX negates: quotient if the operand signs differ, remainder if a<0.
  - Same latency, WIDTH+2.
- Special cases, resolved at E with latency 1 (straight to DONE, no CALC):
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - a==most-negative and b==all-ones (signed DIV/REM): DIV gives a, REM gives 0.
- DONE:
  - out_valid=1 for exactly one cycle; result and zero hold until the next completion.
  - If a new op is accepted in DONE, it is handled as from IDLE, so ALU ops sustain 1 per cycle.
  - Otherwise the next state is IDLE.
- flush:
  - From any state, next state is IDLE and out_valid=0 next cycle.
  - result/zero are not updated.
  - flush and in_valid in the same cycle: nothing is accepted.
- reset:
  - state=IDLE, out_valid=0, result=0, zero=1, counter=0, internal accumulators 0.
  - Mid-operation reset discards the work.
- No back-pressure on output: the consumer must take the result on out_valid.

Test Plan:
1. WIDTH=32:
   - ADD a=7FFFFFFF b=1 -> result 80000000, out_valid at E+1.
   - SLT a=80000000 b=1 -> 1.
   - SLTU same operands -> 0.
   - SRA a=F0000000 b=24 (shamt 4) -> FF000000, zero=0.
2. MULH a=FFFFFFFF(-1) b=00000002 -> FFFFFFFF at exactly E+34; in_ready=0 for cycles E+1..E+33.
   - MULHU with the same operands -> 00000001.
   - MUL with the same operands -> FFFFFFFE.
3. Division:
   - DIV a=-7 b=2 -> FFFFFFFD (-3).
   - REM a=-7 b=2 -> FFFFFFFF (-1).
   - DIVU a=7 b=0 -> FFFFFFFF at E+1.
   - REM a=80000000 b=FFFFFFFF -> 0 with zero=1 at E+1.
4. Pipelining: back-to-back ALU ops ADD 1+1, XOR 5^5, OR 0|0 in consecutive cycles -> out_valid high 3 consecutive cycles with results 2, 0 (zero=1), 0.
5. Flush and reset abort: DIVU accepted, flush asserted at E+10 -> no out_valid, in_ready=1 at E+11, previous result held. Repeat with reset instead -> result=0, zero=1.
6. WIDTH=8: MULHSU a=80(-128) b=FF(255) -> high byte of -32640 = 80, at E+10. Reserved op 01111 -> result 0, zero=1, at E+1.
